axis_pl_to_ps: RTL and testbench
================================

# axis_pl_to_ps

Width down-converter carrying 256-bit AXI-Stream beats from the PL sample/capture path back to the 32-bit (parameterisable) PS DMA stream. It is the return-direction counterpart of the PS-to-PL up-converter. It uses one 256-bit holding register plus a 256-bit serialiser, and sustains one PS word per clock during back-to-back streaming. The slice order is most-significant slice first: bits [255:224] go out first and [31:0] last. This is the exact inverse of the PS-to-PL packing, so a loopback reproduces the original PS word order.

## Interface
- ps_axis_width, 32, PS-side data width; must divide 256 (8, 16, 32, 64, 128).
- ps_per_pl, 256/ps_axis_width, slices per PL beat (derived, not overridden).
- clk  in  1  single clock for both sides.
- rst  in  1  reset; asynchronous, active-low.
- channel_select  in  16  nonzero enables acceptance of new PL beats.
- s_axis_tdata  in  256  PL beat.
- s_axis_tvalid  in  1  PL beat valid.
- s_axis_tready  out  1  block can take a PL beat.
- m_axis_tdata  out  ps_axis_width  current slice to PS.
- m_axis_tvalid  out  1  slice valid.
- m_axis_tready  in  1  PS accepts slice.
- tx_count  out  32  slices delivered to PS since reset, wraps at 2^32.

## Operation
- Storage: hold_data[255:0]/hold_full; shift_data[255:0]/shift_valid; slice_cnt, $clog2(ps_per_pl) bits; ready_en.
- s_axis_tready = ready_en && !hold_full && (channel_select != 0); combinational from registers and channel_select only.
- PL accept (s_axis_tvalid && s_axis_tready): hold_data <= s_axis_tdata, hold_full <= 1.
- Load: when hold_full and the serialiser is free, shift_data <= hold_data, shift_valid <= 1, slice_cnt <= 0, hold_full <= 0. The serialiser is free when !shift_valid, or when the last slice is handshaked this cycle.
- m_axis_tdata = shift_data[255 -: ps_axis_width]; m_axis_tvalid = shift_valid.
- PS handshake (m_axis_tvalid && m_axis_tready): tx_count++.
  - Non-last slice: shift_data <<= ps_axis_width and slice_cnt++.
  - Last slice (slice_cnt == ps_per_pl-1): shift_valid <= 0 unless a load occurs the same cycle.
- Simultaneous PL accept and load in one cycle: the load takes the old hold_data and the accept writes the new one, so hold_full stays 1.
- channel_select going to 0 only blocks new acceptance. Held and in-flight beats drain fully.
- m_axis_tdata/tvalid stay stable while tvalid && !tready.

## Timing
- Reset values: s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata 0, tx_count 0. All internal registers are 0.
- ready_en sets on the first clk edge after rst deasserts, so s_axis_tready first rises one cycle after release.
- Latency: beat accepted at edge N, hold loaded at N, shift loaded at N+1, first slice valid after N+1, i.e. 2 cycles from accept to m_axis_tvalid.
- Throughput: with m_axis_tready held high, one slice per clk with no bubble between beats. PL-side rate is 1 beat per ps_per_pl cycles.
- rst asserted mid-beat: partial slices are discarded immediately and asynchronously, and outputs return to reset values. Nothing is replayed.
- The PS side is never starved by hold refill: the next beat loads on the same edge the last slice is consumed.

## Configuration
- PL_TO_PS_TLAST_EN defined: ports s_axis_tlast (in, 1) and m_axis_tlast (out, 1) exist.
  - tlast is captured with the beat into hold, then moved into shift.
  - m_axis_tlast = shift_tlast && (slice_cnt == ps_per_pl-1); it resets to 0.
- Undefined: both ports and all tlast storage are absent. The stream is unframed.

## Test plan
- Reset release, channel_select=1, m_axis_tready=1 -> s_axis_tready 0 during reset and high 1 cycle after; outputs 0.
- Single beat 256'h0001..0008 (slice k = k+1, MSB first) -> m_axis_tdata 32'h1,2,...,8 on 8 consecutive cycles starting 2 cycles after accept; tx_count=8.
- 4 back-to-back beats, tready=1 -> 32 contiguous valid slices with no bubble; tx_count=32; s_axis_tready low while hold is full.
- m_axis_tready toggled 1/0 every cycle -> data held stable on stalls; all 8 slices in order; no beat is lost or duplicated.
- channel_select=0 mid-stream with one beat held -> current and held beats fully drain; the next s_axis_tvalid is not accepted until channel_select is nonzero.
- PL_TO_PS_TLAST_EN: 2 beats, second with tlast=1 -> m_axis_tlast high only on slice 16; rst pulsed mid-beat -> m_axis_tvalid 0 immediately.

Source files
------------

// File: rtl/axis_pl_to_ps_if.sv
// AXI-Stream channel bundle shared by the PL (256-bit) and PS (narrow) sides of the
// PL-to-PS down-converter.
//
// Parameters:
//   Width  - tdata width of this channel.
// Signals:
//   tdata   - beat / slice payload
//   tvalid  - payload valid
//   tready  - sink can take the payload
//   tlast   - end of frame (present only when PL_TO_PS_TLAST_EN is defined)
// Modports:
//   master  - drives tdata/tvalid(/tlast), samples tready
//   slave   - samples tdata/tvalid(/tlast), drives tready
//
// Build option: define PL_TO_PS_TLAST_EN to carry tlast framing.

interface axis_pl_to_ps_if #(
  parameter int unsigned Width = 32
);

  logic [Width-1:0] tdata;
  logic             tvalid;
  logic             tready;

`ifdef PL_TO_PS_TLAST_EN
  logic             tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
`else
  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
`endif

endinterface

// File: rtl/axis_pl_to_ps.sv
// 256-bit PL AXI-Stream to narrow PS AXI-Stream width down-converter.
//
// Each accepted PL beat is parked in a holding register, then moved into a serialiser
// that emits ps_per_pl slices, most-significant slice first ([255 -: ps_axis_width]
// leaves first, [ps_axis_width-1:0] last). The holding register refills the
// serialiser on the same edge that consumes its last slice, so the PS side streams
// one slice per clock with no bubble between beats.
//
// Parameters:
//   ps_axis_width  - PS-side data width; must divide 256.
// Ports:
//   clk             - single clock for both sides
//   rst             - asynchronous, active-low reset
//   channel_select  - nonzero enables acceptance of new PL beats
//   s_axis          - PL-side slave stream (256-bit tdata)
//   m_axis          - PS-side master stream (ps_axis_width tdata)
//   tx_count        - slices handed to the PS since reset, wraps at 2^32
//
// Build option: PL_TO_PS_TLAST_EN adds tlast on both streams. tlast travels with its
// beat and is presented on the last slice of that beat only. Without the macro the
// stream is unframed and no tlast storage exists.

module axis_pl_to_ps #(
  parameter int unsigned ps_axis_width = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            channel_select,
  axis_pl_to_ps_if.slave         s_axis,
  axis_pl_to_ps_if.master        m_axis,
  output logic [31:0]            tx_count
);

  localparam int unsigned PlWidth   = 256;
  localparam int unsigned ps_per_pl = PlWidth / ps_axis_width;
  localparam int unsigned CntW      = (ps_per_pl > 1) ? $clog2(ps_per_pl) : 1;
  localparam logic [CntW-1:0] LastSlice = CntW'(ps_per_pl - 1);

  // State
  logic                 ready_en_q,    ready_en_d;
  logic [PlWidth-1:0]   hold_data_q,   hold_data_d;
  logic                 hold_full_q,   hold_full_d;
  logic [PlWidth-1:0]   shift_data_q,  shift_data_d;
  logic                 shift_valid_q, shift_valid_d;
  logic [CntW-1:0]      slice_cnt_q,   slice_cnt_d;
  logic [31:0]          tx_count_q,    tx_count_d;
`ifdef PL_TO_PS_TLAST_EN
  logic                 hold_tlast_q,  hold_tlast_d;
  logic                 shift_tlast_q, shift_tlast_d;
`endif

  // Handshake decode
  logic s_ready;
  logic pl_accept;
  logic ps_hs;
  logic last_slice;
  logic ser_free;
  logic load;

  always_comb begin
    s_ready    = ready_en_q && !hold_full_q && (channel_select != 16'd0);
    pl_accept  = s_axis.tvalid && s_ready;
    ps_hs      = shift_valid_q && m_axis.tready;
    last_slice = (slice_cnt_q == LastSlice);
    // Serialiser is free when idle, or when its final slice leaves on this edge.
    ser_free   = !shift_valid_q || (ps_hs && last_slice);
    load       = hold_full_q && ser_free;
  end

  // Next-state
  always_comb begin
    ready_en_d    = 1'b1;
    hold_data_d   = hold_data_q;
    hold_full_d   = hold_full_q;
    shift_data_d  = shift_data_q;
    shift_valid_d = shift_valid_q;
    slice_cnt_d   = slice_cnt_q;
    tx_count_d    = tx_count_q;
`ifdef PL_TO_PS_TLAST_EN
    hold_tlast_d  = hold_tlast_q;
    shift_tlast_d = shift_tlast_q;
`endif

    // Holding register: a load empties it, an accept (which wins) refills it.
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (pl_accept) begin
      hold_data_d = s_axis.tdata;
      hold_full_d = 1'b1;
`ifdef PL_TO_PS_TLAST_EN
      hold_tlast_d = s_axis.tlast;
`endif
    end

    // Serialiser: a load always takes the old hold contents.
    if (load) begin
      shift_data_d  = hold_data_q;
      shift_valid_d = 1'b1;
      slice_cnt_d   = '0;
`ifdef PL_TO_PS_TLAST_EN
      shift_tlast_d = hold_tlast_q;
`endif
    end else if (ps_hs) begin
      if (last_slice) begin
        shift_valid_d = 1'b0;
      end else begin
        shift_data_d = shift_data_q << ps_axis_width;
        slice_cnt_d  = slice_cnt_q + 1'b1;
      end
    end

    if (ps_hs) begin
      tx_count_d = tx_count_q + 32'd1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q    <= 1'b0;
      hold_data_q   <= '0;
      hold_full_q   <= 1'b0;
      shift_data_q  <= '0;
      shift_valid_q <= 1'b0;
      slice_cnt_q   <= '0;
      tx_count_q    <= '0;
`ifdef PL_TO_PS_TLAST_EN
      hold_tlast_q  <= 1'b0;
      shift_tlast_q <= 1'b0;
`endif
    end else begin
      ready_en_q    <= ready_en_d;
      hold_data_q   <= hold_data_d;
      hold_full_q   <= hold_full_d;
      shift_data_q  <= shift_data_d;
      shift_valid_q <= shift_valid_d;
      slice_cnt_q   <= slice_cnt_d;
      tx_count_q    <= tx_count_d;
`ifdef PL_TO_PS_TLAST_EN
      hold_tlast_q  <= hold_tlast_d;
      shift_tlast_q <= shift_tlast_d;
`endif
    end
  end

  // Outputs
  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = shift_data_q[PlWidth-1 -: ps_axis_width];
  assign m_axis.tvalid = shift_valid_q;
`ifdef PL_TO_PS_TLAST_EN
  assign m_axis.tlast  = shift_tlast_q && last_slice;
`endif
  assign tx_count      = tx_count_q;

endmodule

// File: tb/tb_axis_pl_to_ps.sv
// Scoreboard bench for axis_pl_to_ps. Each accepted PL beat is cut into PS slices
// (most-significant first) by the reference model and queued; an independent monitor
// compares every presented slice with the queue head and retires it on handshake.

`timescale 1ns/1ps

module tb_axis_pl_to_ps;

  localparam int unsigned PsW    = 32;
  localparam int unsigned Slices = 256 / PsW;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] channel_select;
  logic [31:0] tx_count;

  axis_pl_to_ps_if #(.Width(256)) s_if ();
  axis_pl_to_ps_if #(.Width(PsW)) m_if ();

  axis_pl_to_ps #(
    .ps_axis_width(PsW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .channel_select (channel_select),
    .s_axis         (s_if.slave),
    .m_axis         (m_if.master),
    .tx_count       (tx_count)
  );

  always #5 clk = ~clk;

  // Bookkeeping
  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  cycle = 0;
  int           tready_mode;  // 0 high, 1 toggle, 2 random, 3 low
  logic [PsW-1:0] exp_q[$];
  bit           exp_last_q[$];
  int unsigned  hs_cyc[$];    // cycle stamp of each PS handshake
  int unsigned  tlast_pos[$]; // slice index (since reset) carrying tlast
  logic [31:0]  exp_tx;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one PL beat becomes Slices words, top slice first.
  task automatic push_beat(input logic [255:0] d, input bit last);
    for (int k = 0; k < Slices; k++) begin
      exp_q.push_back(d[255 - k*PsW -: PsW]);
      exp_last_q.push_back(last && (k == Slices - 1));
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_last_q.delete();
    hs_cyc.delete();
    tlast_pos.delete();
    exp_tx = '0;
  endtask

  // PS tready driver
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ~m_if.tready;
        2:       m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst && m_if.tvalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_tvalid", 256'(m_if.tvalid), 256'd0);
        end else begin
          check("slice_data", 256'(m_if.tdata), 256'(exp_q[0]));
`ifdef PL_TO_PS_TLAST_EN
          check("slice_tlast", 256'(m_if.tlast), 256'(exp_last_q[0]));
`endif
          if (m_if.tready) begin
            check("tx_count_run", 256'(tx_count), 256'(exp_tx));
`ifdef PL_TO_PS_TLAST_EN
            if (m_if.tlast) tlast_pos.push_back(exp_tx);
`endif
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
            hs_cyc.push_back(cycle);
            exp_tx = exp_tx + 32'd1;
          end
        end
      end
    end
  end

  // Present one PL beat and hold it until accepted (bounded).
  task automatic drive_beat(input logic [255:0] d, input bit last);
    int waited = 0;
    bit done   = 1'b0;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
`ifdef PL_TO_PS_TLAST_EN
    s_if.tlast  = last;
`endif
    while (!done) begin
      @(negedge clk);
      if (s_if.tready) begin
        push_beat(d, last);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 400) begin
          check("accept_timeout", 256'(s_if.tready), 256'd1);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain_complete", 256'(exp_q.size()), 256'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_beat();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] beat_c;
    int unsigned  base;
    int unsigned  hi_cnt;

    rst            = 1'b0;
    channel_select = 16'd1;
    tready_mode    = 0;
    s_if.tdata     = '0;
    s_if.tvalid    = 1'b0;
`ifdef PL_TO_PS_TLAST_EN
    s_if.tlast     = 1'b0;
`endif
    flush_model();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 256'(s_if.tready), 256'd0);
    check("rst_m_tvalid", 256'(m_if.tvalid), 256'd0);
    check("rst_m_tdata",  256'(m_if.tdata),  256'd0);
    check("rst_tx_count", 256'(tx_count),    256'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("s_tready_release_cycle0", 256'(s_if.tready), 256'd0);
    @(negedge clk);
    check("s_tready_release_cycle1", 256'(s_if.tready), 256'd1);
    @(posedge clk);
    #1;

    // Single beat: latency, contiguous slices, tx_count
    hs_cyc.delete();
    drive_beat({32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8}, 1'b0);
    @(negedge clk);
    check("latency_not_yet", 256'(m_if.tvalid), 256'd0);
    @(negedge clk);
    check("latency_valid", 256'(m_if.tvalid), 256'd1);
    check("first_slice_msb", 256'(m_if.tdata), 256'h1);
    wait_drain(100);
    check("single_hs_count", 256'(hs_cyc.size()), 256'(Slices));
    if (hs_cyc.size() == Slices)
      check("single_contiguous", 256'(hs_cyc[Slices-1] - hs_cyc[0]), 256'(Slices - 1));
    check("single_tx_count", 256'(tx_count), 256'd8);

    // Back-to-back beats with tready high: no bubble
    hs_cyc.delete();
    for (int b = 0; b < 4; b++) drive_beat(rand_beat(), 1'b0);
    wait_drain(200);
    check("b2b_hs_count", 256'(hs_cyc.size()), 256'(4 * Slices));
    if (hs_cyc.size() == 4 * Slices)
      check("b2b_no_bubble", 256'(hs_cyc[4*Slices-1] - hs_cyc[0]), 256'(4 * Slices - 1));
    check("b2b_tx_count", 256'(tx_count), 256'd40);

    // tready toggling: stalls must hold data stable (monitor checks each cycle)
    tready_mode = 1;
    drive_beat(rand_beat(), 1'b0);
    drive_beat(rand_beat(), 1'b0);
    wait_drain(200);
    check("toggle_tx_count", 256'(tx_count), 256'(exp_tx));

    // channel_select drop with one beat in flight and one held
    tready_mode = 3;
    drive_beat(rand_beat(), 1'b0);
    drive_beat(rand_beat(), 1'b0);
    channel_select = 16'd0;
    beat_c         = rand_beat();
    s_if.tdata     = beat_c;
    s_if.tvalid    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tready_mode = 0;
    hi_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_if.tready) hi_cnt++;
    end
    check("cs0_blocked", 256'(hi_cnt), 256'd0);
    check("cs0_drained", 256'(exp_q.size()), 256'd0);
    check("cs0_tx_count", 256'(tx_count), 256'(exp_tx));
    @(posedge clk);
    #1;
    channel_select = 16'h8000;
    drive_beat(beat_c, 1'b0);
    wait_drain(100);

    // Randomized traffic
    tready_mode = 2;
    for (int b = 0; b < 30; b++) begin
      channel_select = 16'($urandom_range(1, 16'hFFFF));
      drive_beat(rand_beat(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain(3000);
    check("random_tx_count", 256'(tx_count), 256'(exp_tx));

`ifdef PL_TO_PS_TLAST_EN
    // Framing: tlast only on the 16th slice of a two-beat frame
    tready_mode = 0;
    tlast_pos.delete();
    base = exp_tx;
    drive_beat(rand_beat(), 1'b0);
    drive_beat(rand_beat(), 1'b1);
    wait_drain(100);
    check("tlast_count", 256'(tlast_pos.size()), 256'd1);
    if (tlast_pos.size() == 1)
      check("tlast_position", 256'(tlast_pos[0] - base), 256'(2 * Slices - 1));
`endif

    // Reset mid-beat: outputs clear at once, nothing replays
    tready_mode = 0;
    drive_beat(rand_beat(), 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_m_tvalid", 256'(m_if.tvalid), 256'd0);
    check("midrst_m_tdata",  256'(m_if.tdata),  256'd0);
    check("midrst_tx_count", 256'(tx_count),    256'd0);
    check("midrst_s_tready", 256'(s_if.tready), 256'd0);
`ifdef PL_TO_PS_TLAST_EN
    check("midrst_m_tlast",  256'(m_if.tlast),  256'd0);
`endif
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_replay", 256'(m_if.tvalid), 256'd0);
    @(posedge clk);
    #1;
    drive_beat(rand_beat(), 1'b0);
    wait_drain(100);
    check("post_rst_tx_count", 256'(tx_count), 256'(Slices));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
